// File: rtl/gray_stream_checker.sv
// Gray-code stream checker: decodes each valid Gray sample to binary, checks that
// consecutive samples differ by one bit, tracks direction, errors and lock status.
module gray_stream_checker #(
    parameter int N         = 4,
    parameter int ERR_CNT_W = 8,
    parameter int LOCK_RUN  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         gray_in,
    input  logic                 gray_valid,
    output logic [N-1:0]         bin_out,
    output logic                 bin_valid,
    output logic                 step_err,
    output logic                 dir_up,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 locked
);

    localparam int CW = $clog2(N + 1);
    localparam logic [7:0]    LOCK_RUN_C = 8'(LOCK_RUN);
    localparam logic [CW-1:0] ONE_BIT_C  = {{(CW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    function automatic logic [N-1:0] gray_to_bin(input logic [N-1:0] g);
        logic [N-1:0] b;
        b[N-1] = g[N-1];
        for (int i = N - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [CW-1:0] popcount(input logic [N-1:0] x);
        logic [CW-1:0] c;
        c = {CW{1'b0}};
        for (int i = 0; i < N; i++) begin
            c = c + {{(CW-1){1'b0}}, x[i]};
        end
        return c;
    endfunction

    logic                 s1_valid_q, s1_valid_d;
    logic [N-1:0]         s1_gray_q, s1_gray_d;
    logic                 s2_valid_q, s2_valid_d;
    logic [N-1:0]         s2_gray_q, s2_gray_d;
    logic [N-1:0]         s2_bin_q, s2_bin_d;
    logic [N-1:0]         prev_gray_q, prev_gray_d;
    logic [N-1:0]         prev_bin_q, prev_bin_d;
    state_t               state_q, state_d;
    logic [7:0]           run_q, run_d;
    logic [N-1:0]         bin_out_q, bin_out_d;
    logic                 bin_valid_q, bin_valid_d;
    logic                 step_err_q, step_err_d;
    logic                 dir_up_q, dir_up_d;
    logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
    logic                 locked_q, locked_d;

    logic [CW-1:0]        dist_s;
    logic                 good_s;
    logic                 jump_s;
    logic                 up_s;

    // Stage 1 capture and stage 2 decode; registers hold when no sample moves through.
    always_comb begin
        s1_valid_d = gray_valid;
        s2_valid_d = s1_valid_q;
        s2_gray_d  = s2_gray_q;
        s2_bin_d   = s2_bin_q;
        if (gray_valid) begin
            s1_gray_d = gray_in;
        end else begin
            s1_gray_d = s1_gray_q;
        end
        if (s1_valid_q) begin
            s2_gray_d = s1_gray_q;
            s2_bin_d  = gray_to_bin(s1_gray_q);
        end else begin
            s2_gray_d = s2_gray_q;
            s2_bin_d  = s2_bin_q;
        end
    end

    // Classification of the stage-2 sample against the last valid sample.
    always_comb begin
        dist_s = popcount(s2_gray_q ^ prev_gray_q);
        good_s = (dist_s == ONE_BIT_C);
        jump_s = (dist_s > ONE_BIT_C);
        up_s   = (s2_bin_q == (prev_bin_q + {{(N-1){1'b0}}, 1'b1}));
    end

    // Lock FSM, error counting and output register next-state.
    always_comb begin
        prev_gray_d = prev_gray_q;
        prev_bin_d  = prev_bin_q;
        state_d     = state_q;
        run_d       = run_q;
        bin_out_d   = bin_out_q;
        bin_valid_d = 1'b0;
        step_err_d  = 1'b0;
        dir_up_d    = dir_up_q;
        err_count_d = err_count_q;
        if (s2_valid_q) begin
            bin_valid_d = 1'b1;
            bin_out_d   = s2_bin_q;
            prev_gray_d = s2_gray_q;
            prev_bin_d  = s2_bin_q;
            if (state_q != ST_IDLE) begin
                if (good_s) begin
                    dir_up_d = up_s;
                end else if (jump_s) begin
                    step_err_d = 1'b1;
                    if (err_count_q != {ERR_CNT_W{1'b1}}) begin
                        err_count_d = err_count_q + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        err_count_d = err_count_q;
                    end
                end else begin
                    dir_up_d = dir_up_q;
                end
            end else begin
                dir_up_d = dir_up_q;
            end
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_ACQUIRE;
                    run_d   = 8'd0;
                end
                ST_ACQUIRE: begin
                    if (good_s) begin
                        if ((run_q + 8'd1) == LOCK_RUN_C) begin
                            state_d = ST_LOCKED;
                            run_d   = 8'd0;
                        end else begin
                            run_d = run_q + 8'd1;
                        end
                    end else if (jump_s) begin
                        run_d = 8'd0;
                    end else begin
                        run_d = run_q;
                    end
                end
                ST_LOCKED: begin
                    if (jump_s) begin
                        state_d = ST_ACQUIRE;
                        run_d   = 8'd0;
                    end else begin
                        state_d = ST_LOCKED;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    run_d   = 8'd0;
                end
            endcase
        end else begin
            bin_valid_d = 1'b0;
        end
        locked_d = (state_d == ST_LOCKED);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_gray_q   <= {N{1'b0}};
            s2_valid_q  <= 1'b0;
            s2_gray_q   <= {N{1'b0}};
            s2_bin_q    <= {N{1'b0}};
            prev_gray_q <= {N{1'b0}};
            prev_bin_q  <= {N{1'b0}};
            state_q     <= ST_IDLE;
            run_q       <= 8'd0;
            bin_out_q   <= {N{1'b0}};
            bin_valid_q <= 1'b0;
            step_err_q  <= 1'b0;
            dir_up_q    <= 1'b1;
            err_count_q <= {ERR_CNT_W{1'b0}};
            locked_q    <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_gray_q   <= s1_gray_d;
            s2_valid_q  <= s2_valid_d;
            s2_gray_q   <= s2_gray_d;
            s2_bin_q    <= s2_bin_d;
            prev_gray_q <= prev_gray_d;
            prev_bin_q  <= prev_bin_d;
            state_q     <= state_d;
            run_q       <= run_d;
            bin_out_q   <= bin_out_d;
            bin_valid_q <= bin_valid_d;
            step_err_q  <= step_err_d;
            dir_up_q    <= dir_up_d;
            err_count_q <= err_count_d;
            locked_q    <= locked_d;
        end
    end

    assign bin_out   = bin_out_q;
    assign bin_valid = bin_valid_q;
    assign step_err  = step_err_q;
    assign dir_up    = dir_up_q;
    assign err_count = err_count_q;
    assign locked    = locked_q;

endmodule

// File: tb/tb_gray_stream_checker.sv
// Bench for gray_stream_checker: directed vector table with hand expectations plus
// random stimulus, all checked against an arithmetic reference model.
module tb_gray_stream_checker;

    localparam int LR = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] gray_in = 4'd0;
    logic       gray_valid = 1'b0;
    logic [3:0] bin_out, bin_out2;
    logic       bin_valid, bin_valid2, step_err, step_err2, dir_up, dir_up2, locked, locked2;
    logic [7:0] err_count;
    logic [1:0] err_count2;

    gray_stream_checker #(.N(4), .ERR_CNT_W(8), .LOCK_RUN(LR)) dut (
        .clk(clk), .rst(rst), .gray_in(gray_in), .gray_valid(gray_valid),
        .bin_out(bin_out), .bin_valid(bin_valid), .step_err(step_err),
        .dir_up(dir_up), .err_count(err_count), .locked(locked)
    );

    gray_stream_checker #(.N(4), .ERR_CNT_W(2), .LOCK_RUN(LR)) dut_sat (
        .clk(clk), .rst(rst), .gray_in(gray_in), .gray_valid(gray_valid),
        .bin_out(bin_out2), .bin_valid(bin_valid2), .step_err(step_err2),
        .dir_up(dir_up2), .err_count(err_count2), .locked(locked2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       r;
        logic       v;
        logic [3:0] g;
        logic       chk;
        logic [3:0] bin;
        logic       err;
        logic       dir;
        logic       lck;
        logic [1:0] c2;
    } vec_t;

    typedef struct {
        logic       bv;
        logic [3:0] bin;
        logic       err;
        logic       dir;
        logic [7:0] cnt;
        logic [1:0] cnt2;
        logic       lck;
        vec_t       hand;
    } exp_t;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state (abstract: last sample, good-step run, lock flag)
    bit         m_have;
    int         m_prev_g, m_prev_b, m_run, m_cnt, m_cnt2;
    bit         m_lock, m_dir;
    int         m_bin;

    exp_t pipe [3];
    vec_t tbl [$];

    function automatic int g2b(input int g);
        int b = 0;
        for (int k = 0; k < 4; k++) b = b ^ (g >> k);
        return b & 15;
    endfunction

    function automatic vec_t mk(input logic r, input logic v, input logic [3:0] g,
                                input logic [3:0] bin, input logic err, input logic dir,
                                input logic lck, input logic [1:0] c2);
        vec_t t;
        t.r = r; t.v = v; t.g = g; t.chk = v & ~r;
        t.bin = bin; t.err = err; t.dir = dir; t.lck = lck; t.c2 = c2;
        return t;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_have = 0; m_prev_g = 0; m_prev_b = 0; m_run = 0; m_cnt = 0; m_cnt2 = 0;
        m_lock = 0; m_dir = 1; m_bin = 0;
    endtask

    task automatic model_apply(input int g, output bit err);
        int b, d;
        b = g2b(g);
        err = 0;
        if (!m_have) begin
            m_have = 1;
            m_run = 0;
        end else begin
            d = $countones(g ^ m_prev_g);
            if (d == 1) begin
                m_dir = (b == ((m_prev_b + 1) % 16));
                if (!m_lock) begin
                    m_run++;
                    if (m_run >= LR) m_lock = 1;
                end
            end else if (d >= 2) begin
                err = 1;
                if (m_cnt < 255) m_cnt++;
                if (m_cnt2 < 3) m_cnt2++;
                m_lock = 0;
                m_run = 0;
            end
        end
        m_prev_g = g;
        m_prev_b = b;
        m_bin = b;
    endtask

    task automatic step(input vec_t t);
        exp_t e;
        bit err;
        rst = t.r; gray_valid = t.v; gray_in = t.g;
        err = 0;
        if (t.r) begin
            model_reset();
        end else if (t.v) begin
            model_apply(int'(t.g), err);
        end
        e.bv = t.v & ~t.r; e.err = err; e.bin = 4'(m_bin); e.dir = m_dir;
        e.cnt = 8'(m_cnt); e.cnt2 = 2'(m_cnt2); e.lck = m_lock; e.hand = t;
        if (t.r) begin
            pipe[0] = e; pipe[1] = e; pipe[2] = e;
        end else begin
            pipe[2] = pipe[1]; pipe[1] = pipe[0]; pipe[0] = e;
        end
        @(posedge clk);
        #1;
        e = pipe[2];
        chk("bin_valid", bin_valid, e.bv);
        chk("step_err", step_err, e.err);
        chk("dir_up", dir_up, e.dir);
        chk("err_count", err_count, e.cnt);
        chk("locked", locked, e.lck);
        chk("bin_out", bin_out, e.bin);
        chk("err_count_w2", err_count2, e.cnt2);
        if (e.hand.chk && e.bv) begin
            chk("vec_bin", bin_out, e.hand.bin);
            chk("vec_step_err", step_err, e.hand.err);
            chk("vec_dir_up", dir_up, e.hand.dir);
            chk("vec_locked", locked, e.hand.lck);
            chk("vec_err_count_w2", err_count2, e.hand.c2);
        end
    endtask

    initial begin
        vec_t t;
        logic [3:0] lastg;
        // initial reset
        tbl.push_back(mk(1'b1, 1'b0, 4'h0, 4'd0, 1'b0, 1'b1, 1'b0, 2'd0));
        tbl.push_back(mk(1'b1, 1'b0, 4'h0, 4'd0, 1'b0, 1'b1, 1'b0, 2'd0));
        // ascending 0..15 then wrap to 0
        for (int i = 0; i < 16; i++)
            tbl.push_back(mk(1'b0, 1'b1, 4'(i ^ (i >> 1)), 4'(i), 1'b0, 1'b1, (i >= 4), 2'd0));
        tbl.push_back(mk(1'b0, 1'b1, 4'b0000, 4'd0,  1'b0, 1'b1, 1'b1, 2'd0));
        // descending through the wrap
        tbl.push_back(mk(1'b0, 1'b1, 4'b0000, 4'd0,  1'b0, 1'b1, 1'b1, 2'd0));
        tbl.push_back(mk(1'b0, 1'b1, 4'b1000, 4'd15, 1'b0, 1'b0, 1'b1, 2'd0));
        tbl.push_back(mk(1'b0, 1'b1, 4'b1001, 4'd14, 1'b0, 1'b0, 1'b1, 2'd0));
        tbl.push_back(mk(1'b0, 1'b1, 4'b1011, 4'd13, 1'b0, 1'b0, 1'b1, 2'd0));
        // climb back up to 1, then illegal jump while locked and relock
        tbl.push_back(mk(1'b0, 1'b1, 4'b1001, 4'd14, 1'b0, 1'b1, 1'b1, 2'd0));
        tbl.push_back(mk(1'b0, 1'b1, 4'b1000, 4'd15, 1'b0, 1'b1, 1'b1, 2'd0));
        tbl.push_back(mk(1'b0, 1'b1, 4'b0000, 4'd0,  1'b0, 1'b1, 1'b1, 2'd0));
        tbl.push_back(mk(1'b0, 1'b1, 4'b0001, 4'd1,  1'b0, 1'b1, 1'b1, 2'd0));
        tbl.push_back(mk(1'b0, 1'b1, 4'b0010, 4'd3,  1'b1, 1'b1, 1'b0, 2'd1));
        tbl.push_back(mk(1'b0, 1'b1, 4'b0011, 4'd2,  1'b0, 1'b0, 1'b0, 2'd1));
        tbl.push_back(mk(1'b0, 1'b1, 4'b0001, 4'd1,  1'b0, 1'b0, 1'b0, 2'd1));
        tbl.push_back(mk(1'b0, 1'b1, 4'b0000, 4'd0,  1'b0, 1'b0, 1'b0, 2'd1));
        tbl.push_back(mk(1'b0, 1'b1, 4'b0001, 4'd1,  1'b0, 1'b1, 1'b1, 2'd1));
        // repeat across idle gaps
        tbl.push_back(mk(1'b0, 1'b1, 4'b0011, 4'd2,  1'b0, 1'b1, 1'b1, 2'd1));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(1'b0, 1'b0, 4'b1111, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0));
        tbl.push_back(mk(1'b0, 1'b1, 4'b0011, 4'd2,  1'b0, 1'b1, 1'b1, 2'd1));
        tbl.push_back(mk(1'b0, 1'b1, 4'b0010, 4'd3,  1'b0, 1'b1, 1'b1, 2'd1));
        // reset mid-stream with samples in flight
        tbl.push_back(mk(1'b0, 1'b1, 4'b0110, 4'd4,  1'b0, 1'b1, 1'b1, 2'd1));
        tbl.push_back(mk(1'b0, 1'b1, 4'b0111, 4'd5,  1'b0, 1'b1, 1'b1, 2'd1));
        tbl.push_back(mk(1'b1, 1'b1, 4'b0101, 4'd0,  1'b0, 1'b1, 1'b0, 2'd0));
        tbl.push_back(mk(1'b1, 1'b1, 4'b0100, 4'd0,  1'b0, 1'b1, 1'b0, 2'd0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(1'b0, 1'b0, 4'b0000, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0));
        // saturation of the narrow error counter
        for (int i = 0; i < 6; i++)
            tbl.push_back(mk(1'b0, 1'b1, (i % 2 == 1) ? 4'b0011 : 4'b0000,
                             (i % 2 == 1) ? 4'd2 : 4'd0, (i > 0), 1'b1, 1'b0,
                             (i > 3) ? 2'd3 : 2'(i)));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(1'b0, 1'b0, 4'b0000, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0));

        model_reset();
        foreach (tbl[i]) step(tbl[i]);

        lastg = 4'd0;
        for (int i = 0; i < 800; i++) begin
            int mode;
            t = mk(1'b0, 1'b0, lastg, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0);
            t.chk = 1'b0;
            t.r = ($urandom_range(0, 79) == 0);
            t.v = ($urandom_range(0, 3) != 0);
            mode = $urandom_range(0, 5);
            if (mode <= 2)      t.g = lastg ^ (4'b0001 << $urandom_range(0, 3));
            else if (mode == 3) t.g = lastg;
            else                t.g = 4'($urandom_range(0, 15));
            if (t.v && !t.r) lastg = t.g;
            step(t);
        end
        for (int i = 0; i < 3; i++) step(mk(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
